// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the APB-fronted sync FIFO.
// Window selects, the depth-code register layout and the code-to-depth mapping.
package sync_fifo_pkg;

  localparam logic CFG_WIN  = 1'b0;
  localparam logic DATA_WIN = 1'b1;

  localparam int              CODE_W   = 3;
  localparam logic [CODE_W-1:0] CODE_RST = 3'd1;
  localparam logic [CODE_W-1:0] CODE_MIN = 3'd1;

  // Largest legal code for a given physical depth: depth 8 << (code-1) must fit.
  function automatic logic [CODE_W-1:0] code_max(input int max_depth);
    return CODE_W'($clog2(max_depth) - 2);
  endfunction

  function automatic logic [31:0] depth_from_code(input logic [CODE_W-1:0] code);
    return 32'd8 << (code - 3'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// FIFO storage, pointers and occupancy count with a run-time active depth.
// Pointers wrap at the active depth; flush clears pointers and count only.
module sync_fifo_core #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [$clog2(MAX_DEPTH):0]   i_depth,
  input  logic [WIDTH-1:0]             i_wr_data,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [MAX_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr_last;
  logic             w_rd_last;

  assign w_wr_last = ({1'b0, r_wr_ptr} == (i_depth - 1'b1));
  assign w_rd_last = ({1'b0, r_rd_ptr} == (i_depth - 1'b1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_push) begin
      r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
      r_count  <= r_count + 1'b1;
    end else if (i_pop) begin
      r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == i_depth);
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/sync_fifo.sv
// APB slave front end: address decode, depth-code register and error responses.
// PRESETn is a legacy name; it is an active-high synchronous reset.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 256
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic [2:0]  PPROT,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        full,
  output logic        empty
);

  localparam int CW = $clog2(MAX_DEPTH) + 1;
  localparam logic [CODE_W-1:0] CODE_MAX = code_max(MAX_DEPTH);

  logic [CODE_W-1:0] r_code;
  logic [CW-1:0]     w_depth;
  logic [WIDTH-1:0]  w_rd_data;
  logic              w_access;
  logic              w_cfg_sel;
  logic              w_data_sel;
  logic              w_code_legal;
  logic              w_cfg_wr_ok;
  logic              w_cfg_wr_err;
  logic              w_push;
  logic              w_push_err;
  logic              w_pop;
  logic              w_pop_err;
  logic              w_cfg_rd;
  logic              w_unused;

  assign PREADY     = 1'b1;
  assign w_access   = PSEL & PENABLE & PREADY;
  assign w_cfg_sel  = w_access & (PADDR[31] == CFG_WIN);
  assign w_data_sel = w_access & (PADDR[31] == DATA_WIN);

  assign w_code_legal = (PWDATA[CODE_W-1:0] >= CODE_MIN) && (PWDATA[CODE_W-1:0] <= CODE_MAX);
  assign w_cfg_wr_ok  = w_cfg_sel & PWRITE & PSTRB[0] & w_code_legal;
  assign w_cfg_wr_err = w_cfg_sel & PWRITE & ~(PSTRB[0] & w_code_legal);
  assign w_cfg_rd     = w_cfg_sel & ~PWRITE;

  assign w_push     = w_data_sel & PWRITE & PSTRB[0] & ~full;
  assign w_push_err = w_data_sel & PWRITE & ~(PSTRB[0] & ~full);
  assign w_pop      = w_data_sel & ~PWRITE & ~empty;
  assign w_pop_err  = w_data_sel & ~PWRITE & empty;

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_code <= CODE_RST;
    end else if (w_cfg_wr_ok) begin
      r_code <= PWDATA[CODE_W-1:0];
    end
  end

  assign w_depth = CW'(depth_from_code(r_code));

  sync_fifo_core #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_core (
    .i_clk     (PCLK),
    .i_rst     (PRESETn),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_cfg_wr_ok),
    .i_depth   (w_depth),
    .i_wr_data (PWDATA[WIDTH-1:0]),
    .o_rd_data (w_rd_data),
    .o_full    (full),
    .o_empty   (empty)
  );

  // Show-ahead read: data comes from the entry at rd_ptr before the closing edge.
  always_comb begin
    PRDATA = 32'd0;
    if (w_cfg_rd)   PRDATA = 32'(r_code);
    else if (w_pop) PRDATA = 32'(w_rd_data);
  end

  assign PSLVERR = w_cfg_wr_err | w_push_err | w_pop_err;

  assign w_unused = ^{PPROT, PADDR, PWDATA, PSTRB};

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, depth-8 fill/drain, config errors,
// depth-256 fill with pointer wrap, flush on config write, reset mid-transfer.
module tb_sync_fifo;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] CFG  = 32'h0000_0000;
  localparam logic [31:0] DATA = 32'h8000_0000;

  sync_fifo #(.WIDTH(8), .MAX_DEPTH(256)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PPROT   (PPROT),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .full    (full),
    .empty   (empty)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int j);
    return 8'(j * 7 + 3);
  endfunction

  logic [31:0] rd;
  logic        er;
  logic [7:0]  bytes [8];

  initial begin
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h00; bytes[3] = 8'hFF;
    bytes[4] = 8'h5A; bytes[5] = 8'hC3; bytes[6] = 8'h81; bytes[7] = 8'h7E;
    PADDR = '0; PPROT = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0; PSTRB = '0;
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b0;

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_slverr", 32'(PSLVERR), 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd1);
    chk("idle_prdata", PRDATA, 32'd0);
    apb(0, CFG, 0, 4'h0, rd, er);
    chk("rst_cfg_rd", rd, 32'h1);
    chk("rst_cfg_rd_err", 32'(er), 32'd0);

    apb(1, CFG, 32'h1, 4'h1, rd, er);
    chk("cfg_wr1_err", 32'(er), 32'd0);
    apb(0, CFG, 0, 4'h0, rd, er);
    chk("cfg_rd1", rd, 32'h0000_0001);
    chk("cfg_rd1_err", 32'(er), 32'd0);

    apb(1, DATA, 32'h55, 4'h0, rd, er);
    chk("wr_nostrb_err", 32'(er), 32'd1);
    chk("wr_nostrb_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 8; i++) begin
      apb(1, DATA, {24'hABCDEF, bytes[i]}, 4'h1, rd, er);
      chk("d8_wr_err", 32'(er), 32'd0);
      if (i == 6) chk("d8_full_at7", 32'(full), 32'd0);
    end
    chk("d8_full", 32'(full), 32'd1);
    apb(1, DATA, 32'h11, 4'h1, rd, er);
    chk("d8_over_err", 32'(er), 32'd1);
    chk("d8_over_full", 32'(full), 32'd1);

    for (int i = 0; i < 8; i++) begin
      apb(0, DATA, 0, 4'h0, rd, er);
      chk("d8_rd_data", rd, {24'h0, bytes[i]});
      chk("d8_rd_err", 32'(er), 32'd0);
    end
    chk("d8_empty", 32'(empty), 32'd1);
    apb(0, DATA, 0, 4'h0, rd, er);
    chk("d8_under_data", rd, 32'd0);
    chk("d8_under_err", 32'(er), 32'd1);

    apb(1, CFG, 32'h7, 4'h1, rd, er);
    chk("cfg_wr7_err", 32'(er), 32'd1);
    apb(1, CFG, 32'h2, 4'h0, rd, er);
    chk("cfg_nostrb_err", 32'(er), 32'd1);
    apb(0, CFG, 0, 4'h0, rd, er);
    chk("cfg_rd_after_bad", rd, 32'h1);

    apb(1, CFG, 32'hFFFF_FFF6, 4'h1, rd, er);
    chk("cfg_wr6_err", 32'(er), 32'd0);
    for (int j = 0; j < 256; j++) begin
      apb(1, DATA, 32'(pat(j)), 4'h1, rd, er);
      if (j == 254) chk("d256_full_at255", 32'(full), 32'd0);
    end
    chk("d256_full", 32'(full), 32'd1);
    for (int k = 0; k < 300; k++) begin
      apb(0, DATA, 0, 4'h0, rd, er);
      chk("wrap_rd_data", rd, 32'(pat(k)));
      apb(1, DATA, 32'(pat(256 + k)), 4'h1, rd, er);
    end
    chk("wrap_full", 32'(full), 32'd1);
    apb(0, DATA, 0, 4'h0, rd, er);
    chk("wrap_rd_tail", rd, 32'(pat(300)));

    apb(1, CFG, 32'h1, 4'h1, rd, er);
    for (int i = 0; i < 3; i++) apb(1, DATA, 32'(8'h20 + i), 4'h1, rd, er);
    chk("hold3_not_empty", 32'(empty), 32'd0);
    apb(1, CFG, 32'h2, 4'h1, rd, er);
    chk("flush_err", 32'(er), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    apb(0, CFG, 0, 4'h0, rd, er);
    chk("cfg_rd2", rd, 32'h2);
    apb(0, DATA, 0, 4'h0, rd, er);
    chk("flush_rd_err", 32'(er), 32'd1);

    apb(1, DATA, 32'h61, 4'h1, rd, er);
    apb(1, DATA, 32'h62, 4'h1, rd, er);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = DATA; PWDATA = 32'h63; PSTRB = 4'h1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESETn = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    apb(0, CFG, 0, 4'h0, rd, er);
    chk("midrst_cfg", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
